gyro_display_scheduler: RTL and testbench
=========================================

Name: gyro_display_scheduler

Overview:
- Sequences the gyro display datapath: keeps the latest X/Y/Z/temperature samples from the SPI interface and, on a periodic refresh tick, picks one axis.
- Presents that axis's sample as a stable sel/data pair and fires a one-cycle start pulse to the binary-to-BCD conversion path.
- Holds sel/data for a fixed conversion window.
- Axis choice is either from the switches or auto-rotated on a slow timer.

Parameters:
- REFRESH_DIV, 100000, clk cycles between refresh ticks (1 kHz at 100 MHz); must be >= BCD_WAIT+4.
- BCD_WAIT, 32, cycles sel/data are held after start; covers BCD conversion latency.
- ROTATE_COUNT, 2000, completed refreshes per axis in auto-rotate mode.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- samp_valid  in  1  one-cycle strobe, new sample available
- samp_axis  in  2  axis of sample: 0=X, 1=Y, 2=Z, 3=TEMP
- samp_data  in  16  two's-complement sample (TEMP raw)
- freeze  in  1  1 = ignore samp_valid (display hold)
- auto_rotate  in  1  1 = rotate axes automatically
- axis_sw  in  2  manual axis select
- sel  out  2  axis presented to datapath
- data  out  16  sample presented to datapath
- start  out  1  one-cycle conversion start pulse
- busy  out  1  high while a refresh is in progress

Behaviour:
- Reset and clocking:
  - All logic is synchronous to clk. rst is sampled on clk and has priority over everything else.
  - On reset: sel=0, data=0, start=0, busy=0, all four bank registers=0, all counters=0, state=IDLE, pending=0, rot_axis=0.
  - Reset mid-refresh aborts the refresh. No start is issued in the reset cycle or after it for the aborted refresh.
- Sample bank:
  - When samp_valid=1 and freeze=0: bank[samp_axis] <= samp_data.
  - When freeze=1: samp_valid is discarded.
- Tick generator:
  - Free-running counter 0..REFRESH_DIV-1.
  - tick=1 for one cycle when count==REFRESH_DIV-1, then wraps to 0.
- FSM, states IDLE, LOAD, START, WAIT:
  - IDLE: if tick or pending, go to LOAD and clear pending.
  - LOAD: axis = auto_rotate ? rot_axis : axis_sw. Register sel<=axis and data<=bank[axis].
    - Bypass: if samp_valid=1, freeze=0 and samp_axis==axis in this cycle, data<=samp_data.
    - Next state START.
  - START: start=1 for exactly this cycle. Load wait counter with BCD_WAIT-1. Next state WAIT.
  - WAIT: decrement the wait counter. At 0, go to IDLE and increment the refresh count.
- Latency:
  - Tick in IDLE at cycle t: LOAD at t+1, sel/data valid from t+2, start high at t+2.
  - WAIT occupies t+3..t+2+BCD_WAIT. IDLE at t+3+BCD_WAIT.
- busy: registered so it is high exactly in LOAD, START and WAIT cycles.
- Stability: sel and data change only on the clock edge ending the LOAD cycle. They hold through START and WAIT and remain at their last value in IDLE.
- Tick while not IDLE: set pending. At most one pending refresh; further ticks are dropped.
- Auto-rotate:
  - Refresh counter increments on each WAIT->IDLE transition.
  - On reaching ROTATE_COUNT: clear the counter and advance rot_axis 0->1->2->3->0.
  - Rising edge of auto_rotate (registered previous value): rot_axis<=axis_sw and counter<=0.
  - While auto_rotate=0, rot_axis tracks axis_sw every cycle.
- Arithmetic: the block does no arithmetic on samples; data is passed bit-exact. Counters use $clog2-sized unsigned widths; no overflow beyond terminal count.

Decomposition:
- Shared package gyro_disp_pkg:
  - state enum {IDLE, LOAD, START, WAIT}.
  - Axis constants AXIS_X=2'd0, AXIS_Y=2'd1, AXIS_Z=2'd2, AXIS_TEMP=2'd3.
- One sub-module: refresh_tick_gen (parameter DIV; ports clk, rst, tick). It is reusable by the seven-segment anode refresh.

Test Plan:
- Test parameters: REFRESH_DIV=16, BCD_WAIT=4, ROTATE_COUNT=3.
- Reset then write X=16'hFF38 (-200), manual axis_sw=0 -> at first tick+2: sel=0, data=16'hFF38, start high exactly one cycle, busy high 6 cycles (LOAD+START+4 WAIT).
- samp_valid for axis 1 (16'h0064) in the same cycle as LOAD with axis_sw=1 -> data=16'h0064 (bypass). Same write with freeze=1 -> data keeps the old bank value.
- auto_rotate=1 from axis_sw=2 -> sel sequence 2,2,2,3,3,3,0,0,0,1 over 10 refreshes.
- Force a second tick during WAIT (REFRESH_DIV=6 variant, BCD_WAIT=4) -> refresh restarts immediately after IDLE via pending. Three ticks in one refresh -> only one extra refresh.
- Assert rst during WAIT -> next cycle sel=0, data=0, busy=0, start=0, bank cleared. No start pulse until the next tick after release.
- Change axis_sw during WAIT -> sel and data unchanged until the next LOAD.

Source files
------------

// File: rtl/gyro_disp_pkg.sv
// Shared types and constants for the gyro display scheduler.
package gyro_disp_pkg;

    // Refresh sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_e;

    // Axis codes as delivered by the SPI interface.
    localparam logic [1:0] AXIS_X    = 2'd0;
    localparam logic [1:0] AXIS_Y    = 2'd1;
    localparam logic [1:0] AXIS_Z    = 2'd2;
    localparam logic [1:0] AXIS_TEMP = 2'd3;

    // Auto-rotate order X -> Y -> Z -> TEMP -> X.
    function automatic logic [1:0] next_axis(input logic [1:0] axis);
        return axis + 2'd1;
    endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// The tick is registered and high in the cycle where the count equals DIV-1.
module refresh_tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

    logic [CW-1:0] count_r;
    logic          tick_r;

    // Count 0..DIV-1 and raise the tick one cycle ahead so it lines up with LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
            tick_r  <= 1'b0;
        end else begin
            if (count_r == LAST) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CW'(1);
            end
            tick_r <= (count_r == PRE);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/gyro_display_scheduler.sv
// Gyro display scheduler: banks the latest sample per axis, and on every
// refresh tick presents one axis as a held sel/data pair with a start pulse.
module gyro_display_scheduler
    import gyro_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BCD_WAIT     = 32,
    parameter int ROTATE_COUNT = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        samp_valid,
    input  logic [1:0]  samp_axis,
    input  logic [15:0] samp_data,
    input  logic        freeze,
    input  logic        auto_rotate,
    input  logic [1:0]  axis_sw,
    output logic [1:0]  sel,
    output logic [15:0] data,
    output logic        start,
    output logic        busy
);

    localparam int            WW        = (BCD_WAIT > 1) ? $clog2(BCD_WAIT) : 1;
    localparam int            RW        = $clog2(ROTATE_COUNT + 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(BCD_WAIT - 1);
    localparam logic [RW-1:0] ROT_LAST  = RW'(ROTATE_COUNT - 1);

    state_e        state_r;
    state_e        state_nxt_s;
    logic          tick_s;
    logic          take_s;
    logic          refresh_done_s;
    logic          pending_r;
    logic [WW-1:0] wait_cnt_r;
    logic [RW-1:0] refresh_cnt_r;
    logic [1:0]    rot_axis_r;
    logic          auto_prev_r;
    logic [15:0]   bank_r [4];
    logic [1:0]    axis_s;
    logic [15:0]   load_data_s;
    logic          samp_wr_s;
    logic [1:0]    sel_r;
    logic [15:0]   data_r;
    logic          start_r;
    logic          busy_r;

    refresh_tick_gen #(.DIV(REFRESH_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    assign samp_wr_s = samp_valid & ~freeze;
    assign axis_s    = auto_rotate ? rot_axis_r : axis_sw;

    // Value captured at LOAD: a same-cycle write to the chosen axis bypasses the bank.
    always_comb begin
        load_data_s = bank_r[axis_s];
        if (samp_wr_s && (samp_axis == axis_s)) begin
            load_data_s = samp_data;
        end else begin
            load_data_s = bank_r[axis_s];
        end
    end

    // Next-state logic for the refresh sequence.
    always_comb begin
        state_nxt_s    = state_r;
        take_s         = 1'b0;
        refresh_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (tick_s || pending_r) begin
                    state_nxt_s = LOAD;
                    take_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD:  state_nxt_s = START;
            START: state_nxt_s = WAIT;
            WAIT: begin
                if (wait_cnt_r == '0) begin
                    state_nxt_s    = IDLE;
                    refresh_done_s = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus registered start/busy decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            start_r <= (state_nxt_s == START);
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Single-deep pending refresh for ticks that arrive mid-refresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 1'b0;
        end else if (take_s) begin
            pending_r <= 1'b0;
        end else if (tick_s && (state_r != IDLE)) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Conversion-window counter: loaded in START, counted down through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= '0;
        end else if (state_r == START) begin
            wait_cnt_r <= WAIT_LOAD;
        end else if ((state_r == WAIT) && (wait_cnt_r != '0)) begin
            wait_cnt_r <= wait_cnt_r - WW'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // sel/data change only at the end of LOAD and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r  <= 2'd0;
            data_r <= 16'd0;
        end else if (state_r == LOAD) begin
            sel_r  <= axis_s;
            data_r <= load_data_s;
        end else begin
            sel_r  <= sel_r;
            data_r <= data_r;
        end
    end

    // Latest-sample bank, one register per axis; freeze discards writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                bank_r[i] <= 16'd0;
            end
        end else if (samp_wr_s) begin
            bank_r[samp_axis] <= samp_data;
        end else begin
            bank_r <= bank_r;
        end
    end

    // Auto-rotate: count completed refreshes, step the axis, resync on enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_r <= '0;
            rot_axis_r    <= AXIS_X;
            auto_prev_r   <= 1'b0;
        end else begin
            auto_prev_r <= auto_rotate;
            if (auto_rotate && !auto_prev_r) begin
                rot_axis_r    <= axis_sw;
                refresh_cnt_r <= '0;
            end else begin
                if (refresh_done_s) begin
                    if (refresh_cnt_r == ROT_LAST) begin
                        refresh_cnt_r <= '0;
                        if (auto_rotate) begin
                            rot_axis_r <= next_axis(rot_axis_r);
                        end else begin
                            rot_axis_r <= axis_sw;
                        end
                    end else begin
                        refresh_cnt_r <= refresh_cnt_r + RW'(1);
                    end
                end else begin
                    refresh_cnt_r <= refresh_cnt_r;
                end
                if (!auto_rotate) begin
                    rot_axis_r <= axis_sw;
                end else begin
                    rot_axis_r <= rot_axis_r;
                    if (refresh_done_s && (refresh_cnt_r == ROT_LAST)) begin
                        rot_axis_r <= next_axis(rot_axis_r);
                    end else begin
                        rot_axis_r <= rot_axis_r;
                    end
                end
            end
        end
    end

    assign sel   = sel_r;
    assign data  = data_r;
    assign start = start_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_gyro_display_scheduler.sv
// Self-checking bench for gyro_display_scheduler with an in-bench reference model.
module tb_gyro_display_scheduler;

    localparam int DIV  = 16;
    localparam int BW   = 4;
    localparam int RC   = 3;
    localparam int DIV2 = 6;

    logic        clk = 1'b0;
    logic        rst, rst2, samp_valid, freeze, auto_rotate;
    logic [1:0]  samp_axis, axis_sw;
    logic [15:0] samp_data;
    logic [1:0]  sel, sel2;
    logic [15:0] data, data2;
    logic        start, start2, busy, busy2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    gyro_display_scheduler #(.REFRESH_DIV(DIV), .BCD_WAIT(BW), .ROTATE_COUNT(RC)) dut (
        .clk(clk), .rst(rst), .samp_valid(samp_valid), .samp_axis(samp_axis),
        .samp_data(samp_data), .freeze(freeze), .auto_rotate(auto_rotate),
        .axis_sw(axis_sw), .sel(sel), .data(data), .start(start), .busy(busy)
    );

    gyro_display_scheduler #(.REFRESH_DIV(DIV2), .BCD_WAIT(BW), .ROTATE_COUNT(RC)) dut2 (
        .clk(clk), .rst(rst2), .samp_valid(samp_valid), .samp_axis(samp_axis),
        .samp_data(samp_data), .freeze(freeze), .auto_rotate(auto_rotate),
        .axis_sw(axis_sw), .sel(sel2), .data(data2), .start(start2), .busy(busy2)
    );

    // ---------------- reference model ----------------
    // m_age: -1 when no refresh is running, else cycles since the refresh began
    // (0 = axis capture, 1 = start pulse, 2..BW+1 = conversion window).
    logic [15:0] m_bank [4];
    int          m_tcnt, m_age, m_done, m_nage;
    bit          m_pend, m_prev, m_tick, m_fin;
    logic [1:0]  m_rot, m_sel, m_ax;
    logic [15:0] m_data;
    logic        m_start, m_busy;
    logic [19:0] m_vec, dut_vec;

    assign m_vec   = {m_sel, m_data, m_start, m_busy};
    assign dut_vec = {sel, data, start, busy};

    always_comb begin
        m_tick = (m_tcnt == DIV - 1);
        m_fin  = (m_age == BW + 1);
        m_ax   = auto_rotate ? m_rot : axis_sw;
        if (m_age < 0) m_nage = (m_tick || m_pend) ? 0 : -1;
        else           m_nage = m_fin ? -1 : m_age + 1;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_bank[i] <= 16'd0;
            m_tcnt <= 0; m_age <= -1; m_done <= 0; m_pend <= 1'b0; m_prev <= 1'b0;
            m_rot <= 2'd0; m_sel <= 2'd0; m_data <= 16'd0; m_start <= 1'b0; m_busy <= 1'b0;
        end else begin
            m_tcnt <= m_tick ? 0 : m_tcnt + 1;
            m_age  <= m_nage;
            if (m_age < 0 && m_nage == 0) m_pend <= 1'b0;
            else if (m_age >= 0 && m_tick) m_pend <= 1'b1;
            if (m_age == 0) begin
                m_sel  <= m_ax;
                m_data <= (samp_valid && !freeze && samp_axis == m_ax) ? samp_data : m_bank[m_ax];
            end
            m_start <= (m_nage == 1);
            m_busy  <= (m_nage >= 0);
            if (samp_valid && !freeze) m_bank[samp_axis] <= samp_data;
            m_prev <= auto_rotate;
            if (auto_rotate && !m_prev) begin
                m_rot  <= axis_sw;
                m_done <= 0;
            end else begin
                if (m_fin) begin
                    if (m_done + 1 == RC) begin
                        m_done <= 0;
                        if (auto_rotate) m_rot <= m_rot + 2'd1;
                    end else begin
                        m_done <= m_done + 1;
                    end
                end
                if (!auto_rotate) m_rot <= axis_sw;
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({sel, data, start, busy} !== 20'd0) begin
            n_err++; $display("FAIL reset_state got=%h want=%h", {sel, data, start, busy}, 20'd0);
        end
        n_checks++;
        if ({sel2, data2, start2, busy2} !== 20'd0) begin
            n_err++; $display("FAIL reset_state2 got=%h want=%h", {sel2, data2, start2, busy2}, 20'd0);
        end
        n_checks++;
        if (dut_vec !== m_vec) begin
            n_err++; $display("FAIL model_reset got=%h want=%h", dut_vec, m_vec);
        end
        rst = 1'b0;
    endtask

    task automatic test_manual_x();
        int starts = 0; int blen = 0; bit done = 1'b0;
        logic [1:0] s_sel = 2'd3; logic [15:0] s_data = 16'd0;
        samp_valid = 1'b1; samp_axis = 2'd0; samp_data = 16'hFF38; axis_sw = 2'd0;
        @(negedge clk);
        samp_valid = 1'b0;
        for (int i = 0; i < 3 * DIV && !done; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== m_vec) begin
                n_err++; $display("FAIL model_manual t=%0t got=%h want=%h", $time, dut_vec, m_vec);
            end
            if (busy) blen++;
            if (start) begin starts++; s_sel = sel; s_data = data; end
            if (starts > 0 && !busy) done = 1'b1;
        end
        n_checks++;
        if (!done) begin n_err++; $display("FAIL manual_timeout got=0 want=1"); end
        n_checks++;
        if (starts != 1) begin n_err++; $display("FAIL manual_start_pulses got=%0d want=1", starts); end
        n_checks++;
        if (s_sel !== 2'd0) begin n_err++; $display("FAIL manual_sel got=%0d want=0", s_sel); end
        n_checks++;
        if (s_data !== 16'hFF38) begin n_err++; $display("FAIL manual_data got=%h want=ff38", s_data); end
        n_checks++;
        if (blen != 2 + BW) begin n_err++; $display("FAIL manual_busy_len got=%0d want=%0d", blen, 2 + BW); end
    endtask

    task automatic test_bypass_freeze();
        for (int pass = 0; pass < 2; pass++) begin
            logic [15:0] want = (pass == 0) ? 16'h0064 : 16'h1234;
            bit prev; bit found = 1'b0;
            @(negedge clk);
            samp_valid = 1'b1; samp_axis = 2'd1; samp_data = 16'h1234; axis_sw = 2'd1; freeze = 1'b0;
            @(negedge clk);
            samp_valid = 1'b0;
            prev = busy;
            for (int i = 0; i < 3 * DIV && !found; i++) begin
                @(negedge clk);
                n_checks++;
                if (dut_vec !== m_vec) begin
                    n_err++; $display("FAIL model_bypass t=%0t got=%h want=%h", $time, dut_vec, m_vec);
                end
                if (busy && !prev) found = 1'b1;
                prev = busy;
            end
            n_checks++;
            if (!found) begin n_err++; $display("FAIL bypass_timeout pass=%0d got=0 want=1", pass); end
            samp_valid = 1'b1; samp_axis = 2'd1;
            samp_data = (pass == 0) ? 16'h0064 : 16'hBEEF;
            freeze = (pass == 1);
            @(negedge clk);
            samp_valid = 1'b0; freeze = 1'b0;
            n_checks++;
            if ({start, sel, data} !== {1'b1, 2'd1, want}) begin
                n_err++; $display("FAIL bypass_data pass=%0d got=%b/%0d/%h want=1/1/%h", pass, start, sel, data, want);
            end
            for (int i = 0; i < 2 * DIV && busy; i++) begin
                @(negedge clk);
                n_checks++;
                if (dut_vec !== m_vec) begin
                    n_err++; $display("FAIL model_bypass_drain got=%h want=%h", dut_vec, m_vec);
                end
            end
        end
    endtask

    task automatic test_axis_change_wait();
        logic [15:0] r = 16'($urandom);
        bit found = 1'b0; bit found2 = 1'b0;
        @(negedge clk);
        samp_valid = 1'b1; samp_axis = 2'd0; samp_data = r; axis_sw = 2'd0; freeze = 1'b0;
        @(negedge clk);
        samp_valid = 1'b0; freeze = 1'b1;
        for (int i = 0; i < 3 * DIV && !found; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== m_vec) begin
                n_err++; $display("FAIL model_axchg t=%0t got=%h want=%h", $time, dut_vec, m_vec);
            end
            if (start) found = 1'b1;
        end
        n_checks++;
        if (!found || sel !== 2'd0 || data !== r) begin
            n_err++; $display("FAIL axchg_first got=%b/%0d/%h want=1/0/%h", found, sel, data, r);
        end
        axis_sw = 2'd3;
        for (int i = 0; i < 3 * DIV && !found2; i++) begin
            samp_valid = 1'($urandom_range(0, 1)); samp_axis = 2'($urandom); samp_data = 16'($urandom);
            @(negedge clk);
            n_checks++;
            if (dut_vec !== m_vec) begin
                n_err++; $display("FAIL model_axchg_hold t=%0t got=%h want=%h", $time, dut_vec, m_vec);
            end
            if (start) begin
                found2 = 1'b1;
                n_checks++;
                if (sel !== 2'd3) begin n_err++; $display("FAIL axchg_next_sel got=%0d want=3", sel); end
            end else begin
                n_checks++;
                if (sel !== 2'd0 || data !== r) begin
                    n_err++; $display("FAIL axchg_stable got=%0d/%h want=0/%h", sel, data, r);
                end
            end
        end
        n_checks++;
        if (!found2) begin n_err++; $display("FAIL axchg_timeout got=0 want=1"); end
        samp_valid = 1'b0; freeze = 1'b0;
    endtask

    task automatic test_auto_rotate();
        logic [1:0] exp_seq [10] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
        int k = 0;
        for (int i = 0; i < 3 * DIV && busy; i++) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rot_idle_timeout got=%b want=0", busy); end
        axis_sw = 2'd2; auto_rotate = 1'b1; samp_valid = 1'b0;
        for (int i = 0; i < 12 * DIV && k < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== m_vec) begin
                n_err++; $display("FAIL model_rotate t=%0t got=%h want=%h", $time, dut_vec, m_vec);
            end
            if (start) begin
                n_checks++;
                if (sel !== exp_seq[k]) begin
                    n_err++; $display("FAIL rotate_seq idx=%0d got=%0d want=%0d", k, sel, exp_seq[k]);
                end
                k++;
            end
        end
        n_checks++;
        if (k != 10) begin n_err++; $display("FAIL rotate_count got=%0d want=10", k); end
        auto_rotate = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== m_vec) begin
                n_err++; $display("FAIL model_random t=%0t got=%h want=%h", $time, dut_vec, m_vec);
            end
            samp_valid = 1'($urandom_range(0, 1));
            samp_axis  = 2'($urandom);
            samp_data  = 16'($urandom);
            freeze     = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) axis_sw = 2'($urandom);
            if ($urandom_range(0, 63) == 0) auto_rotate = ~auto_rotate;
        end
        samp_valid = 1'b0; freeze = 1'b0; auto_rotate = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        axis_sw = 2'd1;
        for (int i = 0; i < 4 * DIV && !found; i++) begin
            @(negedge clk);
            if (start) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_err++; $display("FAIL rstmid_timeout got=0 want=1"); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({sel, data, start, busy} !== 20'd0) begin
            n_err++; $display("FAIL rstmid_state got=%h want=%h", {sel, data, start, busy}, 20'd0);
        end
        n_checks++;
        if (dut_vec !== m_vec) begin n_err++; $display("FAIL model_rstmid got=%h want=%h", dut_vec, m_vec); end
        rst = 1'b0; freeze = 1'b1;
        for (int i = 0; i < DIV; i++) begin
            @(negedge clk);
            n_checks++;
            if (start !== 1'b0) begin n_err++; $display("FAIL rstmid_no_start cyc=%0d got=%b want=0", i + 1, start); end
        end
        @(negedge clk);
        n_checks++;
        if ({start, sel, data} !== {1'b1, 2'd1, 16'd0}) begin
            n_err++; $display("FAIL rstmid_first got=%b/%0d/%h want=1/1/0000", start, sel, data);
        end
        freeze = 1'b0;
    endtask

    task automatic test_pending();
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        for (int c = 0; c < 50; c++) begin
            bit exp_s, exp_b;
            if (c > 0) @(negedge clk);
            exp_s = (c >= 7) && ((c - 7) % 7 == 0);
            exp_b = (c >= 6) && ((c - 6) % 7 != 6);
            n_checks++;
            if ({start2, busy2} !== {exp_s, exp_b}) begin
                n_err++; $display("FAIL pending_seq cyc=%0d got=%b%b want=%b%b", c, start2, busy2, exp_s, exp_b);
            end
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; samp_valid = 1'b0; samp_axis = 2'd0; samp_data = 16'd0;
        freeze = 1'b0; auto_rotate = 1'b0; axis_sw = 2'd0;
        test_reset();
        test_manual_x();
        test_bypass_freeze();
        test_axis_change_wait();
        test_auto_rotate();
        test_random();
        test_reset_mid();
        test_pending();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
